seq_alu_ctrl: RTL and testbench

Multi-cycle sequencer for the shift and multiply operations. The core datapath provides these only as single-bit shifters and a 32-bit ripple adder. The block iterates that one-step hardware to run shifts of 0–31 places and 32×32 low-word multiplies. It sits beside the single-cycle ALU and is used by the core via a start/busy/done handshake for multi-cycle ops.

---
 rtl/seq_alu_pkg.sv | 22 ++
 rtl/seq_alu_step.sv | 40 ++++
 rtl/seq_alu_ctrl.sv | 111 +++++++++++
 tb/tb_seq_alu_ctrl.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/seq_alu_pkg.sv
// Shared definitions for the multi-cycle shift/multiply sequencer.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package seq_alu_pkg;

    localparam int DEF_WIDTH   = 32;
    localparam int DEF_SHAMT_W = 5;

    typedef enum logic [1:0] {
        OP_SLL = 2'b00,
        OP_SRL = 2'b01,
        OP_SRA = 2'b10,
        OP_MUL = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

endpackage

// File: rtl/seq_alu_step.sv
// One iteration of the sequencer: a 1-bit shift, or one shift-and-add multiply step.
// Latency: combinational.
// Backpressure: none; the caller decides whether to commit the step.
module seq_alu_step
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  op_e              op,
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] mcand,
    input  logic             mb0,
    output logic [WIDTH-1:0] acc_nxt,
    output logic [WIDTH-1:0] mcand_nxt
);

    logic [WIDTH-1:0] sum;

    // Ripple adder; carry out is dropped so MUL keeps only the low word.
    assign sum = acc + mcand;

    // Select the one-step result for the op in flight.
    always_comb begin
        acc_nxt   = acc;
        mcand_nxt = mcand;
        case (op)
            OP_SLL: acc_nxt = {acc[WIDTH-2:0], 1'b0};
            OP_SRL: acc_nxt = {1'b0, acc[WIDTH-1:1]};
            OP_SRA: acc_nxt = {acc[WIDTH-1], acc[WIDTH-1:1]};
            OP_MUL: begin
                if (mb0) begin
                    acc_nxt = sum;
                end
                mcand_nxt = {mcand[WIDTH-2:0], 1'b0};
            end
            default: acc_nxt = acc;
        endcase
    end

endmodule

// File: rtl/seq_alu_ctrl.sv
// Multi-cycle sequencer running shifts of 0-31 places and low-word 32x32 multiplies.
// Latency: shift by n -> done in cycle n+2; MUL -> done in cycle k+2 (k = msb index of b + 1).
// Backpressure: start is only accepted in IDLE; requests while busy are dropped.
module seq_alu_ctrl
    import seq_alu_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int SHAMT_W = DEF_SHAMT_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [1:0]         op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   result
);

    state_e             state;
    op_e                op_q;
    logic [WIDTH-1:0]   acc;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   mb;
    logic [SHAMT_W-1:0] cnt;
    logic [WIDTH-1:0]   acc_nxt;
    logic [WIDTH-1:0]   mcand_nxt;

    seq_alu_step #(
        .WIDTH     (WIDTH)
    ) u_step (
        .op        (op_q),
        .acc       (acc),
        .mcand     (mcand),
        .mb0       (mb[0]),
        .acc_nxt   (acc_nxt),
        .mcand_nxt (mcand_nxt)
    );

    // Sequencer FSM with registered busy/done/result; reset aborts any op in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            op_q   <= OP_SLL;
            acc    <= '0;
            mcand  <= '0;
            mb     <= '0;
            cnt    <= '0;
            result <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        op_q  <= op_e'(op);
                        busy  <= 1'b1;
                        state <= ST_RUN;
                        if (op_e'(op) == OP_MUL) begin
                            acc   <= '0;
                            mcand <= a;
                            mb    <= b;
                            cnt   <= '0;
                        end else begin
                            acc   <= a;
                            mcand <= '0;
                            mb    <= '0;
                            cnt   <= b[SHAMT_W-1:0];
                        end
                    end
                end
                ST_RUN: begin
                    if (op_q == OP_MUL) begin
                        // Stop as soon as no multiplier bits remain.
                        if (mb != '0) begin
                            acc   <= acc_nxt;
                            mcand <= mcand_nxt;
                            mb    <= mb >> 1;
                        end else begin
                            result <= acc;
                            done   <= 1'b1;
                            state  <= ST_DONE;
                        end
                    end else begin
                        if (cnt != '0) begin
                            acc <= acc_nxt;
                            cnt <= cnt - 1'b1;
                        end else begin
                            result <= acc;
                            done   <= 1'b1;
                            state  <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_alu_ctrl.sv
// Directed bench for seq_alu_ctrl: shifts, multiplies, handshake corner cases, mid-op reset.
// Latency: checks done cycle and result for each vector against hand-computed values.
// Backpressure: exercises start during RUN/DONE and start held high.
module tb_seq_alu_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int n_vec = 0;
    int n_err = 0;

    seq_alu_ctrl dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Starts one op from an IDLE negedge and returns at the negedge of the cycle after done.
    // poke: pulse start with other operands during RUN and during DONE.
    // hold: leave start high so the caller's next op is accepted right after done.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] aa,
                          input logic [31:0] bb, input logic [31:0] exp_res, input int exp_cyc,
                          input bit poke, input bit hold);
        int cyc;
        int gap;
        start = 1'b1;
        op    = o;
        a     = aa;
        b     = bb;
        @(negedge clk);
        cyc = 1;
        gap = 0;
        if (!hold) begin
            start = 1'b0;
            op    = ~o;
            a     = ~aa;
            b     = ~bb;
        end
        chk({tag, "_busy_rise"}, {31'd0, busy}, 32'd1);
        while (!done && cyc < 60) begin
            if (!busy) gap++;
            if (poke && cyc == 3) begin
                start = 1'b1;
                op    = 2'b11;
                a     = 32'h0000_0003;
                b     = 32'h0000_0005;
            end
            if (poke && cyc == 4) start = 1'b0;
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_done_cycle"}, cyc, exp_cyc);
        chk({tag, "_result"}, result, exp_res);
        chk({tag, "_busy_gap"}, gap + {31'd0, ~busy}, 32'd0);
        if (poke) begin
            start = 1'b1;
            op    = 2'b01;
            a     = 32'hDEAD_BEEF;
            b     = 32'h0000_0001;
        end
        @(negedge clk);
        if (poke) start = 1'b0;
        chk({tag, "_busy_fall"}, {30'd0, busy, done}, 32'd0);
    endtask

    initial begin
        int extra;
        rst   = 1'b1;
        start = 1'b0;
        op    = 2'b00;
        a     = '0;
        b     = '0;
        #12;
        chk("reset_outputs", {busy, done, 30'd0} | result, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        run_op("sll31", 2'b00, 32'h0000_0001, 32'd31,         32'h8000_0000, 33, 1'b0, 1'b0);
        run_op("sra4",  2'b10, 32'h8000_0000, 32'h0000_0024,  32'hF800_0000, 6,  1'b0, 1'b0);
        run_op("srl4",  2'b01, 32'h8000_0000, 32'h0000_0024,  32'h0800_0000, 6,  1'b0, 1'b0);
        run_op("sra0",  2'b10, 32'h8000_0000, 32'h0000_0000,  32'h8000_0000, 2,  1'b0, 1'b0);
        run_op("mul_m1x3",  2'b11, 32'hFFFF_FFFF, 32'h0000_0003, 32'hFFFF_FFFD, 4,  1'b0, 1'b0);
        run_op("mul_7x0",   2'b11, 32'h0000_0007, 32'h0000_0000, 32'h0000_0000, 2,  1'b0, 1'b0);
        run_op("mul_2p16",  2'b11, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 19, 1'b0, 1'b0);
        run_op("mul_msb",   2'b11, 32'h1234_5678, 32'h8000_0000, 32'h0000_0000, 34, 1'b0, 1'b0);
        run_op("mul_small", 2'b11, 32'h0000_0006, 32'h0000_0007, 32'h0000_002A, 5,  1'b0, 1'b0);

        // Stray starts during RUN and DONE must not disturb the op or create a second one.
        run_op("poke_sll5", 2'b00, 32'h0000_0001, 32'd5, 32'h0000_0020, 7, 1'b1, 1'b0);
        extra = 0;
        for (int i = 0; i < 10; i++) begin
            if (done || busy) extra++;
            @(negedge clk);
        end
        chk("poke_no_extra", extra, 32'd0);
        chk("poke_result_held", result, 32'h0000_0020);

        // start held high: the second op is accepted in the cycle right after done.
        run_op("hold_srl", 2'b01, 32'h0000_00F0, 32'd4, 32'h0000_000F, 6, 1'b0, 1'b1);
        run_op("hold_sll", 2'b00, 32'h0000_0003, 32'd2, 32'h0000_000C, 4, 1'b0, 1'b0);

        // Reset in cycle 10 of a long MUL aborts it with no done pulse.
        start = 1'b1;
        op    = 2'b11;
        a     = 32'h0000_0005;
        b     = 32'hFFFF_FFFF;
        @(negedge clk);
        start = 1'b0;
        for (int i = 1; i < 10; i++) @(negedge clk);
        chk("rst_pre_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_async", {busy, done, 30'd0} | result, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        extra = 0;
        for (int i = 0; i < 40; i++) begin
            if (done || busy) extra++;
            @(negedge clk);
        end
        chk("rst_no_done", extra, 32'd0);
        run_op("post_rst_sll3", 2'b00, 32'h0000_0001, 32'd3, 32'h0000_0008, 5, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
